// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the HEX display scheduler.
// Contents: FSM state enum, Avalon write-word layout, blank pattern and the
// 4-bit to active-low 7-segment lookup (bit0 = segment a ... bit6 = segment g).
package hex_disp_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned VAL_W      = 16;

  localparam logic [27:0] BLANK_PATTERN = 28'hFFFFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DWELL = 2'd3
  } state_t;

  // Word written into the HEX PIO data register; seg0 is the rightmost digit.
  typedef struct packed {
    logic [3:0]       pad;
    logic [SEG_W-1:0] seg3;
    logic [SEG_W-1:0] seg2;
    logic [SEG_W-1:0] seg1;
    logic [SEG_W-1:0] seg0;
  } hex_word_t;

  function automatic logic [SEG_W-1:0] seg_lut(input logic [NIB_W-1:0] nib);
    logic [SEG_W-1:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_display_scheduler_enc.sv
// Combinational hex digit encoder: one nibble to an active-low 7-segment code.
// Ports: nibble (4-bit value), seg_c (7-bit segment pattern, a = bit0).
module hex7seg_enc
  import hex_disp_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  always_comb seg_c = seg_lut(nibble);

endmodule

// File: rtl/hex_display_scheduler.sv
// Rotates NUM_CH 16-bit sensor readings onto the four-digit HEX display,
// writing each encoded pattern to the HEX PIO through an Avalon-MM master.
// Ports: clk/reset_n (sync, active-low); ch_data/ch_valid shadow loads;
// hold freezes rotation; blank forces all segments off; avm_* Avalon write
// master; cur_ch shows the displayed channel; busy is high in LOAD/WRITE.
module hex_display_scheduler
  import hex_disp_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CH*16-1:0]      ch_data,
  input  logic [NUM_CH-1:0]         ch_valid,
  input  logic                      hold,
  input  logic                      blank,
  output logic [1:0]                avm_address,
  output logic                      avm_chipselect,
  output logic                      avm_write_n,
  output logic [31:0]               avm_writedata,
  input  logic                      avm_waitrequest,
  output logic [$clog2(NUM_CH)-1:0] cur_ch,
  output logic                      busy
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NUM_CH - 1);

  state_t           state_q, state_d;
  logic [VAL_W-1:0] shadow_q [NUM_CH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             dirty_q, dirty_d, dirty_set_c, dirty_c;
  logic             blank_q;
  logic             load_c;
  logic [VAL_W-1:0] cur_val_c;
  logic [SEG_W-1:0] seg_c [NUM_DIGITS];
  hex_word_t        word_c;

  assign avm_address = 2'b00;
  assign cur_ch      = ch_q;

  // Latest value per channel.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ch_valid[i]) shadow_q[i] <= ch_data[VAL_W*i +: VAL_W];
      end
    end
  end

  // Encode the displayed channel.
  assign cur_val_c = shadow_q[ch_q];

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_enc
    hex7seg_enc u_enc (
      .nibble (cur_val_c[NIB_W*d +: NIB_W]),
      .seg_c  (seg_c[d])
    );
  end

  always_comb begin
    word_c = '0;
    if (blank) begin
      word_c = hex_word_t'({4'h0, BLANK_PATTERN});
    end else begin
      word_c.seg3 = seg_c[3];
      word_c.seg2 = seg_c[2];
      word_c.seg1 = seg_c[1];
      word_c.seg0 = seg_c[0];
    end
  end

  // Dirty: new data for the shown channel or a blank toggle. The live set
  // term is folded in so a strobe in DWELL reaches LOAD on the next edge.
  assign dirty_set_c = ch_valid[ch_q] | (blank != blank_q);
  assign dirty_c     = dirty_q | dirty_set_c;

  always_comb begin
    dirty_d = dirty_q;
    if (dirty_set_c)           dirty_d = 1'b1;
    else if (state_q == LOAD)  dirty_d = 1'b0;
  end

  // Next-state, dwell counter and channel rotation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    load_c  = 1'b0;
    case (state_q)
      IDLE:  state_d = LOAD;
      LOAD: begin
        load_c  = 1'b1;
        state_d = WRITE;
      end
      WRITE: if (!avm_waitrequest) state_d = DWELL;
      DWELL: begin
        // Dwell keeps counting through a refresh; only the terminal step
        // (the advance) is deferred when a refresh is pending.
        if (!hold && cnt_q != DWELL_LAST) cnt_d = cnt_q + CNT_W'(1);
        if (dirty_c) begin
          state_d = LOAD;
        end else if (!hold && cnt_q == DWELL_LAST) begin
          cnt_d   = '0;
          ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, control and Avalon output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      ch_q           <= '0;
      dirty_q        <= 1'b0;
      blank_q        <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ch_q           <= ch_d;
      dirty_q        <= dirty_d;
      blank_q        <= blank;
      if (load_c) avm_writedata <= word_c;
      avm_chipselect <= (state_d == WRITE);
      avm_write_n    <= (state_d != WRITE);
      busy           <= (state_d == LOAD) || (state_d == WRITE);
    end
  end

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed-sequence bench with random channel data, checked against a
// behavioural model of shadow values, digit encoding and cycle timing.
module tb_hex_display_scheduler;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DWELL  = 8;
  localparam logic [6:0] SEGS [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NUM_CH*16-1:0] ch_data;
  logic [NUM_CH-1:0]    ch_valid;
  logic                 hold;
  logic                 blank;
  logic [1:0]           avm_address;
  logic                 avm_chipselect;
  logic                 avm_write_n;
  logic [31:0]          avm_writedata;
  logic                 avm_waitrequest;
  logic [1:0]           cur_ch;
  logic                 busy;

  int errors = 0;
  int checks = 0;
  int k      = 0;
  int transfers;

  logic [15:0] model_shadow [NUM_CH];
  logic        model_blank;

  always #5 clk = ~clk;

  hex_display_scheduler #(.NUM_CH(NUM_CH), .DWELL_CYCLES(DWELL)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ch_data         (ch_data),
    .ch_valid        (ch_valid),
    .hold            (hold),
    .blank           (blank),
    .avm_address     (avm_address),
    .avm_chipselect  (avm_chipselect),
    .avm_write_n     (avm_write_n),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .cur_ch          (cur_ch),
    .busy            (busy)
  );

  // Expected PIO word for a channel: four nibbles, 7 bits per digit, digit 0 lowest.
  function automatic logic [31:0] expect_word(input int ch);
    logic [31:0] w;
    int unsigned nib;
    if (model_blank) return 32'h0FFFFFFF;
    w = 32'h0;
    for (int d = 0; d < 4; d++) begin
      nib = (int'(model_shadow[ch]) >> (4 * d)) % 16;
      w   = w + (32'(SEGS[nib]) << (7 * d));
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; strobes last exactly one cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    k++;
    ch_valid = '0;
  endtask

  task automatic tick_to(input int target);
    while (k < target) tick();
  endtask

  task automatic run_no_write(input int target, input string tag);
    logic seen;
    seen = 1'b0;
    while (k < target) begin
      tick();
      if (avm_chipselect) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'h0);
  endtask

  // Present random values on the masked channels for the coming edge.
  task automatic strobe(input logic [NUM_CH-1:0] mask);
    logic [15:0] v;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (mask[i]) begin
        v = 16'($urandom);
        ch_data[16*i +: 16] = v;
        model_shadow[i] = v;
      end
    end
    ch_valid = mask;
  endtask

  initial begin
    reset_n = 1'b0; ch_data = '0; ch_valid = '0; hold = 1'b0; blank = 1'b0;
    avm_waitrequest = 1'b0; model_blank = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) model_shadow[i] = 16'h0;

    repeat (3) tick();
    check("rst_cs",     32'(avm_chipselect), 32'h0);
    check("rst_wn",     32'(avm_write_n),    32'h1);
    check("rst_addr",   32'(avm_address),    32'h0);
    check("rst_data",   avm_writedata,       32'h0);
    check("rst_cur_ch", 32'(cur_ch),         32'h0);
    check("rst_busy",   32'(busy),           32'h0);

    // First write two cycles after release, held one cycle.
    reset_n = 1'b1; k = 0;
    tick();
    check("load_cs",   32'(avm_chipselect), 32'h0);
    check("load_busy", 32'(busy),           32'h1);
    tick();
    check("w0_cs",    32'(avm_chipselect), 32'h1);
    check("w0_wn",    32'(avm_write_n),    32'h0);
    check("w0_data",  avm_writedata,       32'h08102040);
    check("w0_busy",  32'(busy),           32'h1);
    check("w0_addr",  32'(avm_address),    32'h0);
    tick();
    check("w0_end_cs", 32'(avm_chipselect), 32'h0);
    check("w0_end_wn", 32'(avm_write_n),    32'h1);

    // Off-screen channels update shadows only.
    strobe(4'b1110);
    run_no_write(10, "offscreen_nowrite");
    check("rot_ch0", 32'(cur_ch), 32'h0);

    // Rotation every DWELL+2 cycles with the captured values.
    for (int n = 1; n <= 4; n++) begin
      tick_to(10 * n + 1);
      check("rot_cur_ch", 32'(cur_ch), 32'(n % 4));
      tick();
      check("rot_cs",   32'(avm_chipselect), 32'h1);
      check("rot_data", avm_writedata,       expect_word(n % 4));
    end

    // Refresh of the shown channel mid-dwell: rewrite at +2, advance delayed 2.
    tick_to(45);
    strobe(4'b0001);
    tick();
    check("dirty_load_cs",   32'(avm_chipselect), 32'h0);
    check("dirty_load_busy", 32'(busy),           32'h1);
    tick();
    check("dirty_cs",   32'(avm_chipselect), 32'h1);
    check("dirty_data", avm_writedata,       expect_word(0));
    run_no_write(52, "dirty_nowrite");
    check("dirty_keep_ch", 32'(cur_ch), 32'h0);
    tick();
    check("dirty_adv_ch", 32'(cur_ch), 32'h1);

    // Slave stall: five waitrequest cycles, six cycles of stable request.
    avm_waitrequest = 1'b1;
    transfers = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stall_cs",   32'(avm_chipselect), 32'h1);
      check("stall_wn",   32'(avm_write_n),    32'h0);
      check("stall_data", avm_writedata,       expect_word(1));
      if (k == 59) avm_waitrequest = 1'b0;
      if (avm_chipselect && !avm_waitrequest) transfers++;
    end
    tick();
    check("stall_end_cs", 32'(avm_chipselect), 32'h0);
    check("stall_xfers",  32'(transfers),      32'h1);

    // Hold for 20 cycles; blank raised meanwhile forces a rewrite.
    tick_to(61);
    hold = 1'b1;
    run_no_write(65, "hold_nowrite");
    blank = 1'b1; model_blank = 1'b1;
    tick();
    check("blank_load_cs", 32'(avm_chipselect), 32'h0);
    tick();
    check("blank_cs",   32'(avm_chipselect), 32'h1);
    check("blank_data", avm_writedata,       32'h0FFFFFFF);
    strobe(4'b1000);
    run_no_write(81, "hold_nowrite2");
    check("hold_ch", 32'(cur_ch), 32'h1);
    hold = 1'b0;
    run_no_write(87, "resume_nowrite");
    check("resume_keep_ch", 32'(cur_ch), 32'h1);
    tick();
    check("resume_adv_ch", 32'(cur_ch), 32'h2);
    tick();
    check("blank2_cs",   32'(avm_chipselect), 32'h1);
    check("blank2_data", avm_writedata,       32'h0FFFFFFF);

    // Lowering blank rewrites the real digits.
    blank = 1'b0; model_blank = 1'b0;
    tick();
    check("unblank_gap_cs", 32'(avm_chipselect), 32'h0);
    tick();
    avm_waitrequest = 1'b1;
    tick();
    check("unblank_cs",   32'(avm_chipselect), 32'h1);
    check("unblank_data", avm_writedata,       expect_word(2));

    // Reset during a stalled write.
    reset_n = 1'b0;
    tick();
    check("midrst_cs",     32'(avm_chipselect), 32'h0);
    check("midrst_wn",     32'(avm_write_n),    32'h1);
    check("midrst_cur_ch", 32'(cur_ch),         32'h0);
    check("midrst_busy",   32'(busy),           32'h0);
    check("midrst_data",   avm_writedata,       32'h0);
    for (int i = 0; i < int'(NUM_CH); i++) model_shadow[i] = 16'h0;
    avm_waitrequest = 1'b0;
    reset_n = 1'b1; k = 0;
    tick();
    check("rerun_load_cs", 32'(avm_chipselect), 32'h0);
    tick();
    check("rerun_cs",   32'(avm_chipselect), 32'h1);
    check("rerun_data", avm_writedata,       expect_word(0));
    tick();
    check("rerun_end_cs", 32'(avm_chipselect), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
